// File: rtl/debounce_pkg.sv
// Shared definitions for the push-button debounce bank: channel FSM states
// and the counter-width helper.
package debounce_pkg;

  typedef enum logic [1:0] {
    ST_REL     = 2'b00,
    ST_REL_CHK = 2'b01,
    ST_PRS     = 2'b10,
    ST_PRS_CHK = 2'b11
  } state_t;

  // Bits needed to hold max_val; never less than one bit.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 1) ? 1 : int'($clog2(max_val + 1));
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One button: synchroniser, debounce FSM, hold timer and auto-repeat timer.
// Input is already polarity-normalised (1 = pressed).
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned STABLE_CYCLES = 250000,
  parameter int unsigned LONG_CYCLES   = 25000000,
  parameter int unsigned REPEAT_CYCLES = 0
) (
  input  logic clk25,
  input  logic rst_n,
  input  logic btn_in,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release,
  output logic btn_long,
  output logic btn_repeat
);

  localparam int unsigned STAB_W    = cnt_width(STABLE_CYCLES);
  localparam int unsigned HOLD_W    = cnt_width(LONG_CYCLES);
  localparam int unsigned REP_W     = cnt_width(REPEAT_CYCLES);
  localparam int unsigned STAB_LAST = STABLE_CYCLES - 2;
  localparam int unsigned HOLD_LAST = LONG_CYCLES - 1;
  localparam int unsigned REP_LAST  = (REPEAT_CYCLES > 0) ? REPEAT_CYCLES - 1 : 0;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_in;
  state_t                 state;
  logic [STAB_W-1:0]      stab_cnt;
  logic [HOLD_W-1:0]      hold_cnt;
  logic [REP_W-1:0]       rep_cnt;
  logic                   held;
  logic                   stab_done;
  logic                   rel_accept;

  always_ff @(posedge clk25 or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], btn_in};
  end

  assign sync_in = sync_q[SYNC_STAGES-1];
  assign held    = (state == ST_PRS) || (state == ST_PRS_CHK);
  // Entry into a CHK state is itself the first stable sample, so the
  // counter completes one short of STABLE_CYCLES.
  assign stab_done  = (stab_cnt == STAB_W'(STAB_LAST));
  assign rel_accept = (state == ST_PRS_CHK) && !sync_in && stab_done;

  always_ff @(posedge clk25 or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_REL;
      stab_cnt    <= '0;
      hold_cnt    <= '0;
      rep_cnt     <= '0;
      btn_level   <= 1'b0;
      btn_press   <= 1'b0;
      btn_release <= 1'b0;
      btn_long    <= 1'b0;
      btn_repeat  <= 1'b0;
    end else begin
      btn_press   <= 1'b0;
      btn_release <= 1'b0;
      btn_long    <= 1'b0;
      btn_repeat  <= 1'b0;

      case (state)
        ST_REL: begin
          if (sync_in) begin
            state    <= ST_REL_CHK;
            stab_cnt <= '0;
          end
        end
        ST_REL_CHK: begin
          if (!sync_in) begin
            state    <= ST_REL;
            stab_cnt <= '0;
          end else if (stab_done) begin
            state     <= ST_PRS;
            stab_cnt  <= '0;
            hold_cnt  <= '0;
            rep_cnt   <= '0;
            btn_level <= 1'b1;
            btn_press <= 1'b1;
          end else begin
            stab_cnt <= stab_cnt + STAB_W'(1);
          end
        end
        ST_PRS: begin
          if (!sync_in) begin
            state    <= ST_PRS_CHK;
            stab_cnt <= '0;
          end
        end
        ST_PRS_CHK: begin
          if (sync_in) begin
            state    <= ST_PRS;
            stab_cnt <= '0;
          end else if (stab_done) begin
            state       <= ST_REL;
            stab_cnt    <= '0;
            btn_level   <= 1'b0;
            btn_release <= 1'b1;
          end else begin
            stab_cnt <= stab_cnt + STAB_W'(1);
          end
        end
        default: state <= ST_REL;
      endcase

      // Long/repeat timing runs through candidate releases but is muted on
      // the cycle the release is accepted.
      if (held && !rel_accept) begin
        if (hold_cnt != HOLD_W'(LONG_CYCLES)) begin
          hold_cnt <= hold_cnt + HOLD_W'(1);
          if (hold_cnt == HOLD_W'(HOLD_LAST)) begin
            btn_long <= 1'b1;
            rep_cnt  <= '0;
          end
        end else if (REPEAT_CYCLES > 0) begin
          if (rep_cnt == REP_W'(REP_LAST)) begin
            btn_repeat <= 1'b1;
            rep_cnt    <= '0;
          end else begin
            rep_cnt <= rep_cnt + REP_W'(1);
          end
        end
      end
    end
  end

endmodule

// File: rtl/debounce_bank.sv
// Multi-channel push-button conditioner: polarity normalisation followed by
// one independent debounce channel per pin.
module debounce_bank
  import debounce_pkg::*;
#(
  parameter int unsigned          CHANNELS      = 2,
  parameter logic [CHANNELS-1:0]  ACTIVE_LOW    = '1,
  parameter int unsigned          SYNC_STAGES   = 2,
  parameter int unsigned          STABLE_CYCLES = 250000,
  parameter int unsigned          LONG_CYCLES   = 25000000,
  parameter int unsigned          REPEAT_CYCLES = 0
) (
  input  logic                clk25,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] btn_pin,
  output logic [CHANNELS-1:0] btn_level,
  output logic [CHANNELS-1:0] btn_press,
  output logic [CHANNELS-1:0] btn_release,
  output logic [CHANNELS-1:0] btn_long,
  output logic [CHANNELS-1:0] btn_repeat
);

  logic [CHANNELS-1:0] btn_norm;

  assign btn_norm = btn_pin ^ ACTIVE_LOW;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    debounce_channel #(
      .SYNC_STAGES  (SYNC_STAGES),
      .STABLE_CYCLES(STABLE_CYCLES),
      .LONG_CYCLES  (LONG_CYCLES),
      .REPEAT_CYCLES(REPEAT_CYCLES)
    ) u_ch (
      .clk25      (clk25),
      .rst_n      (rst_n),
      .btn_in     (btn_norm[i]),
      .btn_level  (btn_level[i]),
      .btn_press  (btn_press[i]),
      .btn_release(btn_release[i]),
      .btn_long   (btn_long[i]),
      .btn_repeat (btn_repeat[i])
    );
  end

endmodule

// File: tb/tb_debounce_bank.sv
// Directed bench for debounce_bank with a run-length behavioural model
// checked every cycle, plus hand-computed latency and vector checks.
module tb_debounce_bank;

  localparam int unsigned   CH     = 2;
  localparam int unsigned   SYNC   = 2;
  localparam int            STABLE = 8;
  localparam int            LONG   = 32;
  localparam int            REP    = 8;
  localparam logic [CH-1:0] AL     = 2'b11;

  logic          clk25 = 1'b0;
  logic          rst_n;
  logic [CH-1:0] btn_pin;
  logic [CH-1:0] btn_level, btn_press, btn_release, btn_long, btn_repeat;

  int n_cmp = 0;
  int n_err = 0;
  logic chk_en = 1'b0;

  always #20 clk25 = ~clk25;

  debounce_bank #(
    .CHANNELS     (CH),
    .ACTIVE_LOW   (AL),
    .SYNC_STAGES  (SYNC),
    .STABLE_CYCLES(STABLE),
    .LONG_CYCLES  (LONG),
    .REPEAT_CYCLES(REP)
  ) dut (
    .clk25      (clk25),
    .rst_n      (rst_n),
    .btn_pin    (btn_pin),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .btn_release(btn_release),
    .btn_long   (btn_long),
    .btn_repeat (btn_repeat)
  );

  // Model: a pin value reaches the filter SYNC edges after it is sampled;
  // the level flips once STABLE consecutive filter samples disagree with it.
  // Long/repeat follow from the number of edges since the accepted press.
  logic [SYNC-1:0] dl [CH];
  int              run   [CH];
  int              since [CH];
  logic [CH-1:0]   e_level, e_press, e_release, e_long, e_repeat;
  logic            seen, acc;

  always @(posedge clk25 or negedge rst_n) begin
    if (!rst_n) begin
      e_level = '0; e_press = '0; e_release = '0; e_long = '0; e_repeat = '0;
      for (int c = 0; c < CH; c++) begin
        dl[c] = '0; run[c] = 0; since[c] = 0;
      end
    end else begin
      e_press = '0; e_release = '0; e_long = '0; e_repeat = '0;
      for (int c = 0; c < CH; c++) begin
        seen  = dl[c][SYNC-1];
        dl[c] = {dl[c][SYNC-2:0], btn_pin[c] ^ AL[c]};
        run[c] = (seen != e_level[c]) ? run[c] + 1 : 0;
        acc = (run[c] == STABLE);
        if (e_level[c]) begin
          since[c]++;
          if (!acc && since[c] == LONG) e_long[c] = 1'b1;
          if (!acc && REP > 0 && since[c] > LONG && ((since[c] - LONG) % REP) == 0)
            e_repeat[c] = 1'b1;
        end
        if (acc) begin
          run[c] = 0;
          e_level[c] = ~e_level[c];
          if (e_level[c]) begin
            e_press[c] = 1'b1;
            since[c] = 0;
          end else begin
            e_release[c] = 1'b1;
          end
        end
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  always @(negedge clk25) begin
    if (chk_en) begin
      check("model_level",   int'(btn_level),   int'(e_level));
      check("model_press",   int'(btn_press),   int'(e_press));
      check("model_release", int'(btn_release), int'(e_release));
      check("model_long",    int'(btn_long),    int'(e_long));
      check("model_repeat",  int'(btn_repeat),  int'(e_repeat));
    end
  end

  // sel: 0 level, 1 press, 2 release, 3 long, 4 repeat.
  task automatic wait_evt(input int sel, input int ch, input int budget, output int n);
    logic hit;
    n = 0;
    hit = 1'b0;
    while (!hit && n < budget) begin
      @(negedge clk25);
      n++;
      case (sel)
        0:       hit = btn_level[ch];
        1:       hit = btn_press[ch];
        2:       hit = btn_release[ch];
        3:       hit = btn_long[ch];
        default: hit = btn_repeat[ch];
      endcase
    end
    if (!hit) begin
      n_cmp++;
      n_err++;
      $display("FAIL wait_evt sel=%0d ch=%0d: got no event, expected one within %0d cycles",
               sel, ch, budget);
      n = -1;
    end
  endtask

  int   n;
  logic sticky;

  initial begin
    btn_pin = 2'b11;
    rst_n   = 1'b0;
    repeat (3) @(negedge clk25);
    rst_n  = 1'b1;
    chk_en = 1'b1;

    // Idle after reset: nothing fires.
    sticky = 1'b0;
    repeat (100) begin
      @(negedge clk25);
      sticky |= |{btn_level, btn_press, btn_release, btn_long, btn_repeat};
    end
    check("idle_quiet", int'(sticky), 0);

    // Single press on channel 0.
    btn_pin[0] = 1'b0;
    wait_evt(0, 0, 40, n);
    check("press_latency", n, 10);
    check("press_vec", int'(btn_press), 1);
    check("ch1_level", int'(btn_level[1]), 0);
    @(negedge clk25);
    check("press_one_cycle", int'(btn_press), 0);
    btn_pin[0] = 1'b1;
    wait_evt(2, 0, 40, n);
    check("release_latency", n, 10);

    // 7-cycle glitch is rejected, 8-cycle pulse is accepted.
    repeat (5) @(negedge clk25);
    btn_pin[0] = 1'b0;
    repeat (7) @(negedge clk25);
    btn_pin[0] = 1'b1;
    sticky = 1'b0;
    repeat (20) begin
      @(negedge clk25);
      sticky |= btn_level[0] | btn_press[0];
    end
    check("glitch_rejected", int'(sticky), 0);
    btn_pin[0] = 1'b0;
    repeat (8) @(negedge clk25);
    btn_pin[0] = 1'b1;
    wait_evt(1, 0, 20, n);
    check("min_pulse_press", n, 2);
    wait_evt(2, 0, 30, n);
    check("min_pulse_release", n, 8);

    // Long press with auto-repeat; release lands on a repeat slot.
    repeat (5) @(negedge clk25);
    btn_pin[0] = 1'b0;
    wait_evt(1, 0, 40, n);
    check("hold_press", n, 10);
    wait_evt(3, 0, 60, n);
    check("long_latency", n, 32);
    wait_evt(4, 0, 20, n);
    check("repeat1_latency", n, 8);
    wait_evt(4, 0, 20, n);
    check("repeat2_latency", n, 8);
    repeat (22) @(negedge clk25);
    btn_pin[0] = 1'b1;
    wait_evt(2, 0, 40, n);
    check("hold_release", n, 10);
    check("no_repeat_on_release", int'(btn_repeat[0]), 0);
    sticky = 1'b0;
    repeat (30) begin
      @(negedge clk25);
      sticky |= btn_repeat[0] | btn_long[0];
    end
    check("repeat_stopped", int'(sticky), 0);

    // Simultaneous press on both channels.
    repeat (5) @(negedge clk25);
    btn_pin = 2'b00;
    wait_evt(1, 0, 40, n);
    check("both_latency", n, 10);
    check("both_press_vec", int'(btn_press), 3);

    // Asynchronous reset while held, then re-acceptance.
    repeat (3) @(negedge clk25);
    #7 rst_n = 1'b0;
    #1;
    check("reset_level", int'(btn_level), 0);
    check("reset_release", int'(btn_release), 0);
    repeat (2) @(negedge clk25);
    rst_n = 1'b1;
    wait_evt(0, 0, 40, n);
    check("reaccept_latency", n, 10);
    check("reaccept_press_vec", int'(btn_press), 3);
    repeat (5) @(negedge clk25);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
